// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: complex samples, 4x4 tiles and
// the read-sequencer state encoding.
package conv_pkg;

  localparam int TILE_ADDR_WIDTH = 13;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
  } complex_t;

  typedef complex_t [3:0][3:0] tile_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/tile_fifo.sv
// Synchronous FIFO of whole tiles. The head entry is read combinationally, so
// it holds steady for as long as the consumer stalls.
module tile_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  tile_t         wdata,
  input  logic          pop,
  output tile_t         rdata,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tile_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_image_tile_reader.sv
// Walks num_tiles consecutive tile-memory addresses and streams the returned
// tiles on a valid/ready port, issuing reads only when buffer space is assured.
module mem_image_tile_reader
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = TILE_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  tile_t                 rd_data,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output tile_t                 tile_data
);

  // Handshake: a tile transfers on every rising edge where tile_valid and
  // tile_ready are both high; tile_valid never depends on tile_ready.

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issue_cnt;
  logic [CNT_WIDTH-1:0]  acc_cnt;
  logic [1:0]            vpipe;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  issue;
  logic                  pop;

  // vpipe[0]: address on rd_addr this cycle; vpipe[1]: RAM data on rd_data.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(vpipe[0]) + (CW+1)'(vpipe[1]);
  assign tile_valid  = (fifo_count != '0);
  assign pop         = tile_valid && tile_ready;
  assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
  assign done        = (state == S_DONE);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = (num_tiles == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (credit_used < (CW+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issue_cnt == num_q - CNT_WIDTH'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (acc_cnt == num_q) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      rd_addr   <= '0;
      vpipe     <= '0;
    end else begin
      state <= state_next;
      vpipe <= {vpipe[0], issue};
      if ((state == S_IDLE) && start) begin
        base_q    <= base_addr;
        num_q     <= num_tiles;
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end else begin
        if (issue) begin
          rd_addr   <= base_q + issue_cnt[ADDR_WIDTH-1:0];
          issue_cnt <= issue_cnt + CNT_WIDTH'(1);
        end
        if (pop) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      end
    end
  end

  tile_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (vpipe[1]),
    .wdata(rd_data),
    .pop  (pop),
    .rdata(tile_data),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_mem_image_tile_reader.sv
// Directed bench for mem_image_tile_reader with a registered-read tile memory
// model and an address-ordered scoreboard of expected tiles.
module tb_mem_image_tile_reader;
  import conv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] num_tiles;
  logic        busy;
  logic        done;
  logic [12:0] rd_addr;
  tile_t       rd_data;
  logic        tile_valid;
  logic        tile_ready;
  tile_t       tile_data;

  int          n_vec;
  int          n_err;
  int          n_acc;
  logic [12:0] exp_q[$];

  mem_image_tile_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_tiles (num_tiles),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_data (tile_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic tile_t make_tile(input logic [12:0] a);
    tile_t t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j].r = {19'd0, a};
        t[i][j].i = ~{19'd0, a};
      end
    return t;
  endfunction

  // tile memory: 1-cycle registered read
  always @(posedge clk) rd_data <= make_tile(rd_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_tile(input string name, input tile_t act, input tile_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got elem00 %h expected elem00 %h", name, act[0][0], exp[0][0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard / stall monitor, sampled mid-cycle
  logic  stalled;
  tile_t held;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'd0, tile_valid}, 32'd1);
        check_tile("stall_data", tile_data, held);
      end
      if (tile_valid && tile_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tile", {19'd0, tile_data[0][0].r[12:0]}, 32'hFFFF_FFFF);
        end else begin
          check_tile("tile_data", tile_data, make_tile(exp_q.pop_front()));
          n_acc++;
        end
      end
      stalled = tile_valid && !tile_ready;
      held    = tile_data;
    end
  end

  // driver: mode 0 ready high, 1 ready high + mid-job start, 2 ready toggle/stall
  task automatic run_job(input logic [12:0] base, input logic [13:0] n, input int mode,
                         output int first, output int donec, output logic [12:0] rd1);
    int          acc0;
    logic [12:0] e;
    acc0 = n_acc;
    for (int k = 0; k < int'(n); k++) exp_q.push_back(base + 13'(k));
    base_addr = base;
    num_tiles = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
    first = -1;
    donec = -1;
    rd1   = 13'h0;
    for (int c = 0; c < 400; c++) begin
      if (tile_valid && first < 0) first = c;
      if (c == 1) begin
        rd1 = rd_addr;
        check("busy_in_job", {31'd0, busy}, {31'd0, (n != 0)});
      end
      if (done) begin
        donec = c;
        break;
      end
      case (mode)
        1: begin
          tile_ready = 1'b1;
          if (c == 2) begin
            start     = 1'b1;
            base_addr = 13'h100;
            num_tiles = 14'd3;
          end else begin
            start = 1'b0;
          end
        end
        2: begin
          tile_ready = (c < 8) ? c[0] : (c >= 18);
          if (c == 17) begin
            e = base + 13'(n_acc - acc0 + 3);
            check("stall_rd_addr", {19'd0, rd_addr}, {19'd0, e});
          end
        end
        default: tile_ready = 1'b1;
      endcase
      tick();
    end
    start = 1'b0;
    tile_ready = 1'b1;
    tick();
    if (donec == 0) rd1 = rd_addr;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("accepted_count", n_acc - acc0, {18'd0, n});
    check("queue_empty", exp_q.size(), 32'd0);
    repeat (5) tick();
    check("no_late_valid", {31'd0, tile_valid}, 32'd0);
  endtask

  typedef struct {
    logic [12:0] base;
    logic [13:0] n;
    int          mode;
    int          exp_first;
    int          exp_done;
    logic [12:0] exp_rd1;
  } vec_t;

  vec_t        vecs[5];
  int          first;
  int          donec;
  logic [12:0] rd1;

  initial begin
    n_vec = 0;
    n_err = 0;
    n_acc = 0;
    stalled = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_tiles = '0;
    tile_ready = 1'b1;

    // first valid 3 cycles after the start edge; done n+4 cycles after it
    vecs[0] = '{13'h0010, 14'd4, 0, 3, 8,  13'h0010};
    vecs[1] = '{13'h1FFE, 14'd4, 0, 3, 8,  13'h1FFE};
    vecs[2] = '{13'h0020, 14'd1, 0, 3, 5,  13'h0020};
    vecs[3] = '{13'h0055, 14'd0, 0, -1, 0, 13'h0020};
    vecs[4] = '{13'h0200, 14'd8, 1, 3, 12, 13'h0200};

    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, tile_valid}, 32'd0);
    check("rst_rd_addr", {19'd0, rd_addr}, 32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].base, vecs[v].n, vecs[v].mode, first, donec, rd1);
      check($sformatf("v%0d_first_valid", v), first, vecs[v].exp_first);
      check($sformatf("v%0d_done_cycle", v), donec, vecs[v].exp_done);
      check($sformatf("v%0d_rd_addr", v), {19'd0, rd1}, {19'd0, vecs[v].exp_rd1});
    end

    // backpressure: alternating ready, then a 10-cycle stall
    run_job(13'h0400, 14'd16, 2, first, donec, rd1);
    check("bp_first_valid", first, 3);
    check("bp_done_seen", {31'd0, (donec > 0)}, 32'd1);

    // reset with two reads in flight
    tile_ready = 1'b0;
    base_addr  = 13'h0300;
    num_tiles  = 14'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_valid", {31'd0, tile_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rd_addr", {19'd0, rd_addr}, 32'd0);
    reset = 1'b0;
    tile_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_valid", {31'd0, tile_valid}, 32'd0);
    end
    run_job(13'h0040, 14'd3, 0, first, donec, rd1);
    check("after_rst_first_valid", first, 3);
    check("after_rst_done_cycle", donec, 7);
    check("after_rst_rd_addr", {19'd0, rd1}, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
